bus_dest_strobe_gen: RTL and testbench
======================================

// Module: bus_dest_strobe_gen
// PURPOSE
//  Registered, handshaked destination-enable generator for the shared data bus.
//  Takes a destination select (or broadcast request) and drives a one-hot
//  load-enable vector d[] for a programmable number of cycles, then reports done.
//  Sits between the bus controller and the register-file/peripheral load enables.
// PARAMETERS
//  SEL_W      3   width of sel input
//  N_DEST     8   number of destinations (width of d); 1 <= N_DEST <= 2**SEL_W
//  PULSE_CYC  1   cycles d stays asserted per request; >= 1, < 2**16
// PORTS
//  clk        in   1        rising-edge clock, sole clock
//  rst        in   1        synchronous reset, active-high
//  req_valid  in   1        request present
//  req_ready  out  1        block can accept request this cycle
//  sel        in   SEL_W    destination index, sampled on accept
//  bcast      in   1        broadcast: enable all N_DEST outputs, sel ignored
//  d          out  N_DEST   registered load-enable vector
//  busy       out  1        1 while d is being driven
//  done       out  1        1-cycle pulse on last cycle d is asserted
//  err        out  1        1-cycle pulse: rejected request (sel >= N_DEST, bcast=0)
// BEHAVIOUR
//  Reset: state=IDLE, d=0, busy=0, done=0, err=0, req_ready=1 after reset edge.
//  Accept = req_valid & req_ready, evaluated at rising edge.
//  FSM states: IDLE, DRIVE.
//  IDLE: req_ready=1, d=0, busy=0.
//   - accept, bcast=1           -> d<=all ones, cnt<=PULSE_CYC-1, go DRIVE.
//   - accept, bcast=0, sel<N_DEST -> d<=(1<<sel), cnt<=PULSE_CYC-1, go DRIVE.
//   - accept, bcast=0, sel>=N_DEST -> err=1 next cycle only, d stays 0, stay IDLE.
//   - no accept                 -> stay IDLE, outputs 0.
//  DRIVE: req_ready=0, busy=1, d held constant.
//   - cnt!=0 -> cnt<=cnt-1, stay DRIVE.
//   - cnt==0 -> done=1 this cycle (combinational on state/cnt); next edge d<=0,
//     go IDLE.
//  Latency: request accepted at edge k -> d asserted cycles k+1..k+PULSE_CYC,
//   done high in cycle k+PULSE_CYC, req_ready high again in cycle k+PULSE_CYC+1.
//  Minimum request spacing: PULSE_CYC+1 cycles; no back-to-back overlap ever.
//  d is always one-hot, all-ones (bcast) or zero; never any other pattern.
//  req_valid/sel/bcast ignored while in DRIVE (not queued).
//  Reset in DRIVE: at reset edge d<=0, state<=IDLE, no done pulse issued.
//  cnt width: clog2(PULSE_CYC) bits, min 1; PULSE_CYC=1 -> d for exactly 1 cycle.
//  err and done never asserted in the same cycle.
// TESTING
//  1 reset: rst high 2 cycles -> d=0, busy=0, done=0, err=0, req_ready=1.
//  2 defaults, sel=5 accepted at edge k -> d=8'b00100000 in cycle k+1 only,
//    done=1 in k+1, req_ready=1 in k+2.
//  3 PULSE_CYC=4, sel=0 -> d=8'b00000001 for 4 cycles, busy=1 for 4, done
//    only in 4th; req_valid held high with sel=7 -> accepted in cycle 5 only.
//  4 bcast=1, sel=3 -> d=8'hFF for PULSE_CYC cycles, done on last.
//  5 N_DEST=6, sel=6 and sel=7 -> err pulse 1 cycle each, d stays 0,
//    req_ready stays 1; sel=5 -> d=6'b100000.
//  6 PULSE_CYC=4, rst asserted in 2nd DRIVE cycle -> d=0 next cycle,
//    no done, req_ready=1; exhaustive sel sweep 0..7 checks one-hot.

Source files
------------

// File: rtl/bus_dest_strobe_gen.sv
// Handshaked destination load-enable generator: drives a one-hot (or broadcast)
// enable vector for PULSE_CYC cycles per accepted request, then pulses done.
module bus_dest_strobe_gen #(
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned N_DEST    = 8,
  parameter int unsigned PULSE_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_bcast,
  output logic [N_DEST-1:0] o_d,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYC - 1);

  typedef enum logic [0:0] {StIdle, StDrive} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [N_DEST-1:0] r_d;
  logic              r_err;

  logic              w_accept;
  logic              w_sel_ok;
  logic              w_cnt_zero;
  logic [N_DEST-1:0] w_onehot;

  assign w_accept   = i_req_valid && o_req_ready;
  assign w_sel_ok   = 32'(i_sel) < N_DEST;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < N_DEST; i++) begin
      w_onehot[i] = (32'(i_sel) == i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_d     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            if (i_bcast) begin
              r_d     <= '1;
              r_cnt   <= CNT_LOAD;
              r_state <= StDrive;
            end else if (w_sel_ok) begin
              r_d     <= w_onehot;
              r_cnt   <= CNT_LOAD;
              r_state <= StDrive;
            end else begin
              // Out-of-range select is dropped; flag it for one cycle.
              r_err <= 1'b1;
            end
          end
        end
        StDrive: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_d     <= '0;
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign o_req_ready = (r_state == StIdle);
  assign o_busy      = (r_state == StDrive);
  assign o_done      = (r_state == StDrive) && w_cnt_zero;
  assign o_d         = r_d;
  assign o_err       = r_err;

endmodule

// File: tb/tb_bus_dest_strobe_gen.sv
// Bench for bus_dest_strobe_gen: three configurations share one stimulus stream
// and are each checked every cycle against a cycle-window reference model.
module tb_bus_dest_strobe_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, bcast;
  logic [2:0] sel;

  logic       ready0, busy0, done0, err0;
  logic       ready1, busy1, done1, err1;
  logic       ready2, busy2, done2, err2;
  logic [7:0] d0, d1;
  logic [5:0] d2;

  // Inst 0: defaults. Inst 1: PULSE_CYC=4. Inst 2: N_DEST=6, PULSE_CYC=4.
  bus_dest_strobe_gen #(.SEL_W(3), .N_DEST(8), .PULSE_CYC(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready0), .i_sel(sel),
    .i_bcast(bcast), .o_d(d0), .o_busy(busy0), .o_done(done0), .o_err(err0));
  bus_dest_strobe_gen #(.SEL_W(3), .N_DEST(8), .PULSE_CYC(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready1), .i_sel(sel),
    .i_bcast(bcast), .o_d(d1), .o_busy(busy1), .o_done(done1), .o_err(err1));
  bus_dest_strobe_gen #(.SEL_W(3), .N_DEST(6), .PULSE_CYC(4)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready2), .i_sel(sel),
    .i_bcast(bcast), .o_d(d2), .o_busy(busy2), .o_done(done2), .o_err(err2));

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  int pcyc [3] = '{1, 4, 4};
  int ndest[3] = '{8, 8, 6};

  // Model: a request accepted at edge k occupies cycles [m_s, m_e] = [k+1, k+P].
  int         cyc;
  int         m_s  [3];
  int         m_e  [3];
  int         m_err[3];
  logic [7:0] m_pat[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] all_ones(input int n);
    return 8'((1 << n) - 1);
  endfunction

  function automatic bit active(input int i);
    return (m_s[i] <= cyc) && (cyc <= m_e[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s[i]   = 1;
      m_e[i]   = 0;
      m_err[i] = -1;
      m_pat[i] = '0;
    end
  endtask

  task automatic check_all();
    logic [7:0] dv[3];
    logic       rv[3], bv[3], nv[3], ev[3];
    logic [7:0] exp_d;
    bit         shape_ok;
    dv = '{d0, d1, {2'b00, d2}};
    rv = '{ready0, ready1, ready2};
    bv = '{busy0, busy1, busy2};
    nv = '{done0, done1, done2};
    ev = '{err0, err1, err2};
    for (int i = 0; i < 3; i++) begin
      exp_d = active(i) ? m_pat[i] : 8'h00;
      check($sformatf("d[%0d]", i), 32'(dv[i]), 32'(exp_d));
      check($sformatf("busy[%0d]", i), 32'(bv[i]), 32'(active(i)));
      check($sformatf("done[%0d]", i), 32'(nv[i]), 32'(active(i) && (cyc == m_e[i])));
      check($sformatf("ready[%0d]", i), 32'(rv[i]), 32'(!active(i)));
      check($sformatf("err[%0d]", i), 32'(ev[i]), 32'(cyc == m_err[i]));
      shape_ok = (dv[i] == 8'h00) || (dv[i] == all_ones(ndest[i])) || ($countones(dv[i]) == 1);
      check($sformatf("shape[%0d]", i), 32'(shape_ok), 32'd1);
    end
  endtask

  // Called just after a rising edge with the inputs that edge sampled.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_s[i]   = 1;
        m_e[i]   = 0;
        m_err[i] = -1;
      end else if (valid && !active(i)) begin
        if (bcast || (int'(sel) < ndest[i])) begin
          m_s[i]   = cyc + 1;
          m_e[i]   = cyc + pcyc[i];
          m_pat[i] = bcast ? all_ones(ndest[i]) : 8'(1 << sel);
        end else begin
          m_err[i] = cyc + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic [2:0] s, input logic b, input logic r);
    valid = v;
    sel   = s;
    bcast = b;
    rst   = r;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    valid = 1'b0;
    sel   = '0;
    bcast = 1'b0;
    rst   = 1'b1;
    cyc   = 0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b0, 3'd0, 1'b0, 1'b1);
    idle(2);

    step(1'b1, 3'd5, 1'b0, 1'b0);
    idle(5);

    step(1'b1, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 3'd7, 1'b0, 1'b0);
    idle(5);

    step(1'b1, 3'd3, 1'b1, 1'b0);
    idle(5);

    step(1'b1, 3'd6, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 3'd7, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 3'd5, 1'b0, 1'b0);
    idle(5);

    // Reset lands in the second DRIVE cycle of the 4-cycle instances.
    step(1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    idle(3);

    for (int s = 0; s < 8; s++) begin
      step(1'b1, 3'(s), 1'b0, 1'b0);
      idle(5);
    end

    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 49) == 0));
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
